// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares one banked-memory port between the I-cache (reads) and
// the D-cache (reads and writebacks). Reads issue in a single cycle, writebacks
// stream BEATS beats from the WR state, and returning bursts are routed to the
// owning cache by line address and assembled into a full line.
module bmem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned BEAT_W = 64,
   parameter int unsigned BEATS  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        i_addr,
   input  logic                     i_read,
   output logic [BEAT_W*BEATS-1:0]  i_rdata,
   output logic                     i_resp,
   input  logic [ADDR_W-1:0]        d_addr,
   input  logic                     d_read,
   input  logic                     d_write,
   input  logic [BEAT_W*BEATS-1:0]  d_wdata,
   output logic [BEAT_W*BEATS-1:0]  d_rdata,
   output logic                     d_resp,
   output logic [ADDR_W-1:0]        bmem_addr,
   output logic                     bmem_read,
   output logic                     bmem_write,
   output logic [BEAT_W-1:0]        bmem_wdata,
   input  logic                     bmem_ready,
   input  logic [ADDR_W-1:0]        bmem_raddr,
   input  logic [BEAT_W-1:0]        bmem_rdata,
   input  logic                     bmem_rvalid
);

   localparam int unsigned LINE_W = BEAT_W * BEATS;
   localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
   localparam int unsigned LA_W   = ADDR_W - OFF_W;
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   typedef enum logic {IDLE, WR} state_t;

   state_t            state_q, state_d;
   logic              rr_q;                  // 0: I-cache wins a tie, 1: D-cache wins
   logic              i_pend, d_pend;
   logic [LA_W-1:0]   i_line, d_line, wr_line;
   logic [CNT_W-1:0]  i_cnt, d_cnt, wr_cnt;
   logic [LINE_W-1:0] i_buf, d_buf, i_line_nx, d_line_nx;
   logic              i_elig, d_elig, grant_i, grant_d;
   logic              i_issue, d_issue, wr_start, wr_last;
   logic              i_match, d_match;
   logic              unused_low;

   // Byte-offset bits are never looked at; reduce them into a sink.
   assign unused_low = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0], bmem_raddr[OFF_W-1:0]};

   // Eligibility, arbitration and bmem strobe generation. Requests are gated by
   // rst_n so the strobes read 0 while reset is held, and a requester whose resp
   // is pulsing is not eligible so its still-high request is not re-issued.
   always_comb begin
      state_d    = state_q;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      wr_start   = 1'b0;
      wr_last    = 1'b0;
      i_elig = rst_n && i_read && !i_pend && !i_resp &&
               !(d_pend && (d_line == i_addr[ADDR_W-1:OFF_W]));
      d_elig = rst_n && (d_read || d_write) && !d_pend && !d_resp &&
               !(i_pend && (i_line == d_addr[ADDR_W-1:OFF_W]));
      case (state_q)
         IDLE: begin
            grant_i = i_elig && (!d_elig || !rr_q);
            grant_d = d_elig && !grant_i;
            if (grant_i) begin
               bmem_read = 1'b1;
               bmem_addr = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end else if (grant_d && d_read) begin
               bmem_read = 1'b1;
               bmem_addr = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end else if (grant_d) begin
               wr_start = 1'b1;
               state_d  = WR;
            end
         end
         WR: begin
            bmem_write = 1'b1;
            bmem_addr  = {wr_line, {OFF_W{1'b0}}};
            bmem_wdata = d_wdata[wr_cnt*BEAT_W +: BEAT_W];
            if (bmem_ready && (wr_cnt == LAST)) begin
               wr_last = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      i_issue = grant_i && bmem_ready;
      d_issue = grant_d && d_read && bmem_ready;
   end

   // Beat matching and line assembly: the incoming beat merged into each buffer.
   always_comb begin
      i_match   = bmem_rvalid && i_pend && (bmem_raddr[ADDR_W-1:OFF_W] == i_line);
      d_match   = bmem_rvalid && d_pend && (bmem_raddr[ADDR_W-1:OFF_W] == d_line);
      i_line_nx = i_buf;
      i_line_nx[i_cnt*BEAT_W +: BEAT_W] = bmem_rdata;
      d_line_nx = d_buf;
      d_line_nx[d_cnt*BEAT_W +: BEAT_W] = bmem_rdata;
   end

   // FSM state, writeback beat counter and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wr_cnt  <= '0;
         wr_line <= '0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (wr_start) begin
            wr_cnt  <= '0;
            wr_line <= d_addr[ADDR_W-1:OFF_W];
         end else if (state_q == WR && bmem_ready) begin
            wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
         end
         if (i_issue)                  rr_q <= 1'b1;
         else if (d_issue || wr_start) rr_q <= 1'b0;
      end
   end

   // I-cache read tracking: pending flag, beat capture and completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_pend  <= 1'b0;
         i_line  <= '0;
         i_cnt   <= '0;
         i_buf   <= '0;
         i_rdata <= '0;
         i_resp  <= 1'b0;
      end else begin
         i_resp <= 1'b0;
         if (i_issue) begin
            i_pend <= 1'b1;
            i_line <= i_addr[ADDR_W-1:OFF_W];
            i_cnt  <= '0;
         end
         if (i_match) begin
            i_buf <= i_line_nx;
            if (i_cnt == LAST) begin
               i_pend  <= 1'b0;
               i_resp  <= 1'b1;
               i_rdata <= i_line_nx;
               i_cnt   <= '0;
            end else begin
               i_cnt <= i_cnt + 1'b1;
            end
         end
      end
   end

   // D-cache read tracking plus writeback completion onto the shared d_resp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_pend  <= 1'b0;
         d_line  <= '0;
         d_cnt   <= '0;
         d_buf   <= '0;
         d_rdata <= '0;
         d_resp  <= 1'b0;
      end else begin
         d_resp <= wr_last;
         if (d_issue) begin
            d_pend <= 1'b1;
            d_line <= d_addr[ADDR_W-1:OFF_W];
            d_cnt  <= '0;
         end
         if (d_match) begin
            d_buf <= d_line_nx;
            if (d_cnt == LAST) begin
               d_pend  <= 1'b0;
               d_resp  <= 1'b1;
               d_rdata <= d_line_nx;
               d_cnt   <= '0;
            end else begin
               d_cnt <= d_cnt + 1'b1;
            end
         end
      end
   end

`ifndef SYNTHESIS
   // Requests must be held until their response.
   assert property (@(posedge clk) disable iff (!rst_n) i_pend |-> i_read)
      else $error("bmem_arbiter: i_read dropped before i_resp");
   assert property (@(posedge clk) disable iff (!rst_n) d_pend |-> d_read)
      else $error("bmem_arbiter: d_read dropped before d_resp");
   assert property (@(posedge clk) disable iff (!rst_n) (state_q == WR) |-> d_write)
      else $error("bmem_arbiter: d_write dropped during writeback");

   // Flag returning beats that no pending read owns; they are discarded.
   always_ff @(posedge clk) begin
      if (rst_n && bmem_rvalid && !i_match && !d_match)
         $warning("bmem_arbiter: dropping unowned beat for %h", bmem_raddr);
   end
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_bmem_arbiter;

   logic         clk;
   logic         rst_n;
   logic [31:0]  i_addr, d_addr, bmem_addr, bmem_raddr;
   logic         i_read, i_resp, d_read, d_write, d_resp;
   logic [255:0] i_rdata, d_rdata, d_wdata;
   logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
   logic [63:0]  bmem_wdata, bmem_rdata;

   int unsigned errors = 0;
   int unsigned checks = 0;

   bmem_arbiter #(.ADDR_W(32), .BEAT_W(64), .BEATS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst_n = 1'b0;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      bmem_rvalid = 1'b0; bmem_ready = 1'b1;
      tick; tick;
      rst_n = 1'b1;
      tick;
   endtask

   function automatic logic [255:0] line_of(input logic [31:0] a);
      line_of = {a, 32'd3, a, 32'd2, a, 32'd1, a, 32'd0};
   endfunction

   task automatic test_reset;
      i_addr = 32'h0000_1234; i_read = 1'b1;
      d_addr = 32'h0000_0040; d_write = 1'b1;
      #1;
      checks++;
      if (bmem_read !== 1'b0 || bmem_write !== 1'b0 || bmem_addr !== 32'h0 || bmem_wdata !== 64'h0) begin
         errors++; $display("FAIL rst_bmem: read=%b write=%b addr=%h wdata=%h, want all 0", bmem_read, bmem_write, bmem_addr, bmem_wdata);
      end
      checks++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== 256'h0 || d_rdata !== 256'h0) begin
         errors++; $display("FAIL rst_resp: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h, want all 0", i_resp, d_resp, i_rdata, d_rdata);
      end
      i_read = 1'b0; d_write = 1'b0;
      rst_n = 1'b1;
      tick;
      checks++;
      if (bmem_read !== 1'b0 || bmem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
         errors++; $display("FAIL rst_idle: read=%b write=%b i_resp=%b d_resp=%b, want 0", bmem_read, bmem_write, i_resp, d_resp);
      end
   endtask

   task automatic test_single_read;
      apply_reset;
      i_addr = 32'h1000_0004; i_read = 1'b1;
      #1;
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h1000_0000) begin
         errors++; $display("FAIL t1_issue: read=%b addr=%h, want 1 10000000", bmem_read, bmem_addr);
      end
      tick;
      checks++;
      if (bmem_read !== 1'b0) begin
         errors++; $display("FAIL t1_pending: read=%b, want 0", bmem_read);
      end
      for (int unsigned k = 0; k < 4; k++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h1000_0000;
         bmem_rdata = {32'(32'h1111_0000 + k), 32'(32'hB0B0_0000 + k)};
         tick;
         if (k < 3) begin
            checks++;
            if (i_resp !== 1'b0) begin
               errors++; $display("FAIL t1_early_resp: beat %0d i_resp=%b, want 0", k, i_resp);
            end
         end
      end
      bmem_rvalid = 1'b0;
      checks++;
      if (i_resp !== 1'b1 || bmem_read !== 1'b0) begin
         errors++; $display("FAIL t1_resp: i_resp=%b bmem_read=%b, want 1 0", i_resp, bmem_read);
      end
      checks++;
      if (i_rdata !== 256'h1111_0003_B0B0_0003_1111_0002_B0B0_0002_1111_0001_B0B0_0001_1111_0000_B0B0_0000) begin
         errors++; $display("FAIL t1_line: i_rdata=%h", i_rdata);
      end
      i_read = 1'b0;
      tick;
      checks++;
      if (i_resp !== 1'b0 || i_rdata !== 256'h1111_0003_B0B0_0003_1111_0002_B0B0_0002_1111_0001_B0B0_0001_1111_0000_B0B0_0000) begin
         errors++; $display("FAIL t1_hold: i_resp=%b i_rdata=%h, want 0 and line held", i_resp, i_rdata);
      end
   endtask

   task automatic test_dual_read;
      apply_reset;
      i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
      i_read = 1'b1; d_read = 1'b1;
      #1;
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_0100) begin
         errors++; $display("FAIL t2_first_i: read=%b addr=%h, want 1 00000100", bmem_read, bmem_addr);
      end
      tick;
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_0200) begin
         errors++; $display("FAIL t2_then_d: read=%b addr=%h, want 1 00000200", bmem_read, bmem_addr);
      end
      tick;
      checks++;
      if (bmem_read !== 1'b0) begin
         errors++; $display("FAIL t2_both_pending: read=%b, want 0", bmem_read);
      end
      for (int unsigned k = 0; k < 4; k++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0200;
         bmem_rdata = {32'(32'hD000_0000 + k), 32'h0000_0200};
         tick;
      end
      bmem_rvalid = 1'b0;
      checks++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
         errors++; $display("FAIL t2_d_first: d_resp=%b i_resp=%b, want 1 0", d_resp, i_resp);
      end
      checks++;
      if (d_rdata !== 256'hD000_0003_0000_0200_D000_0002_0000_0200_D000_0001_0000_0200_D000_0000_0000_0200) begin
         errors++; $display("FAIL t2_d_line: d_rdata=%h", d_rdata);
      end
      d_read = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0100;
         bmem_rdata = {32'(32'hC000_0000 + k), 32'h0000_0100};
         tick;
      end
      bmem_rvalid = 1'b0;
      checks++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
         errors++; $display("FAIL t2_i_second: i_resp=%b d_resp=%b, want 1 0", i_resp, d_resp);
      end
      checks++;
      if (i_rdata !== 256'hC000_0003_0000_0100_C000_0002_0000_0100_C000_0001_0000_0100_C000_0000_0000_0100 ||
          d_rdata !== 256'hD000_0003_0000_0200_D000_0002_0000_0200_D000_0001_0000_0200_D000_0000_0000_0200) begin
         errors++; $display("FAIL t2_lines: i_rdata=%h d_rdata=%h", i_rdata, d_rdata);
      end
      i_read = 1'b0;
      tick;
   endtask

   task automatic test_write;
      apply_reset;
      d_addr  = 32'h0000_0040;
      d_wdata = {64'h0123_4567_89AB_CD03, 64'h0123_4567_89AB_CD02,
                 64'h0123_4567_89AB_CD01, 64'h0123_4567_89AB_CD00};
      d_write = 1'b1;
      #1;
      checks++;
      if (bmem_read !== 1'b0 || bmem_write !== 1'b0) begin
         errors++; $display("FAIL t3_grant: read=%b write=%b, want 0 0", bmem_read, bmem_write);
      end
      tick;
      checks++;
      if (bmem_write !== 1'b1 || bmem_addr !== 32'h0000_0040 || bmem_wdata !== 64'h0123_4567_89AB_CD00) begin
         errors++; $display("FAIL t3_beat0: write=%b addr=%h wdata=%h", bmem_write, bmem_addr, bmem_wdata);
      end
      tick;
      checks++;
      if (bmem_wdata !== 64'h0123_4567_89AB_CD01) begin
         errors++; $display("FAIL t3_beat1: wdata=%h, want 0123456789abcd01", bmem_wdata);
      end
      tick;
      bmem_ready = 1'b0;
      i_addr = 32'h0000_0800; i_read = 1'b1;
      for (int unsigned n = 0; n < 3; n++) begin
         #1;
         checks++;
         if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_wdata !== 64'h0123_4567_89AB_CD02) begin
            errors++; $display("FAIL t3_stall: cycle %0d write=%b read=%b wdata=%h", n, bmem_write, bmem_read, bmem_wdata);
         end
         tick;
      end
      bmem_ready = 1'b1;
      tick;
      checks++;
      if (bmem_wdata !== 64'h0123_4567_89AB_CD03 || d_resp !== 1'b0 || bmem_read !== 1'b0) begin
         errors++; $display("FAIL t3_beat3: wdata=%h d_resp=%b read=%b", bmem_wdata, d_resp, bmem_read);
      end
      tick;
      checks++;
      if (d_resp !== 1'b1 || bmem_write !== 1'b0) begin
         errors++; $display("FAIL t3_resp: d_resp=%b write=%b, want 1 0", d_resp, bmem_write);
      end
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_0800) begin
         errors++; $display("FAIL t3_read_after: read=%b addr=%h, want 1 00000800", bmem_read, bmem_addr);
      end
      d_write = 1'b0;
   endtask

   task automatic test_same_line;
      apply_reset;
      i_addr = 32'h0000_0080; d_addr = 32'h0000_0094;
      i_read = 1'b1; d_read = 1'b1;
      #1;
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_0080) begin
         errors++; $display("FAIL t4_first: read=%b addr=%h, want 1 00000080", bmem_read, bmem_addr);
      end
      for (int unsigned n = 0; n < 2; n++) begin
         tick;
         checks++;
         if (bmem_read !== 1'b0) begin
            errors++; $display("FAIL t4_conflict: cycle %0d read=%b, want 0", n, bmem_read);
         end
      end
      for (int unsigned k = 0; k < 4; k++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0080;
         bmem_rdata = {32'(32'hE000_0000 + k), 32'h0000_0080};
         tick;
      end
      bmem_rvalid = 1'b0;
      checks++;
      if (i_resp !== 1'b1 || i_rdata !== 256'hE000_0003_0000_0080_E000_0002_0000_0080_E000_0001_0000_0080_E000_0000_0000_0080) begin
         errors++; $display("FAIL t4_i_done: i_resp=%b i_rdata=%h", i_resp, i_rdata);
      end
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_0080) begin
         errors++; $display("FAIL t4_d_issue: read=%b addr=%h, want 1 00000080", bmem_read, bmem_addr);
      end
      i_read = 1'b0;
      tick;
      for (int unsigned k = 0; k < 4; k++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0080;
         bmem_rdata = {32'(32'hF000_0000 + k), 32'h0000_0080};
         tick;
      end
      bmem_rvalid = 1'b0;
      checks++;
      if (d_resp !== 1'b1 || d_rdata !== 256'hF000_0003_0000_0080_F000_0002_0000_0080_F000_0001_0000_0080_F000_0000_0000_0080) begin
         errors++; $display("FAIL t4_d_done: d_resp=%b d_rdata=%h", d_resp, d_rdata);
      end
      d_read = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid;
      i_addr = 32'h0000_0300; i_read = 1'b1;
      #1;
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_0300) begin
         errors++; $display("FAIL t5_issue: read=%b addr=%h, want 1 00000300", bmem_read, bmem_addr);
      end
      tick;
      for (int unsigned k = 0; k < 2; k++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0300;
         bmem_rdata = {32'(32'h5000_0000 + k), 32'h0000_0300};
         tick;
      end
      bmem_rvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bmem_read !== 1'b0 || bmem_addr !== 32'h0 || i_resp !== 1'b0 || i_rdata !== 256'h0 || d_rdata !== 256'h0) begin
         errors++; $display("FAIL t5_rst_out: read=%b addr=%h i_resp=%b i_rdata=%h d_rdata=%h", bmem_read, bmem_addr, i_resp, i_rdata, d_rdata);
      end
      i_read = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      tick;
      for (int unsigned k = 2; k < 4; k++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0300;
         bmem_rdata = {32'(32'h5000_0000 + k), 32'h0000_0300};
         tick;
         checks++;
         if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            errors++; $display("FAIL t5_stray: beat %0d i_resp=%b d_resp=%b, want 0 0", k, i_resp, d_resp);
         end
      end
      bmem_rvalid = 1'b0;
      i_read = 1'b1;
      #1;
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_0300) begin
         errors++; $display("FAIL t5_reissue: read=%b addr=%h, want 1 00000300", bmem_read, bmem_addr);
      end
      tick;
      for (int unsigned k = 0; k < 4; k++) begin
         bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0300;
         bmem_rdata = {32'(32'h6000_0000 + k), 32'h0000_0300};
         tick;
      end
      bmem_rvalid = 1'b0;
      checks++;
      if (i_resp !== 1'b1 || i_rdata !== 256'h6000_0003_0000_0300_6000_0002_0000_0300_6000_0001_0000_0300_6000_0000_0000_0300) begin
         errors++; $display("FAIL t5_fresh: i_resp=%b i_rdata=%h", i_resp, i_rdata);
      end
      i_read = 1'b0;
      tick;
   endtask

   task automatic test_fairness;
      logic [31:0] q[$];
      logic [31:0] exp_addr;
      int unsigned beat, grants, i_done, d_done;
      apply_reset;
      beat = 0; grants = 0; i_done = 0; d_done = 0;
      i_addr = 32'h0000_2000; d_addr = 32'h0000_8000;
      i_read = 1'b1; d_read = 1'b1;
      for (int cyc = 0; cyc < 400 && (i_done < 10 || d_done < 10); cyc++) begin
         if (q.size() > 0) begin
            bmem_rvalid = 1'b1; bmem_raddr = q[0];
            bmem_rdata = {q[0], 32'(beat)};
         end else begin
            bmem_rvalid = 1'b0;
         end
         #1;
         if (bmem_read && bmem_ready) begin
            exp_addr = ((grants % 2) == 0) ? i_addr : d_addr;
            checks++;
            if (bmem_addr !== exp_addr) begin
               errors++; $display("FAIL t6_grant: grant %0d addr=%h, want %h", grants, bmem_addr, exp_addr);
            end
            grants++;
            q.push_back(bmem_addr);
         end
         tick;
         if (bmem_rvalid) begin
            if (beat == 3) begin
               beat = 0;
               void'(q.pop_front());
            end else begin
               beat++;
            end
         end
         if (i_resp) begin
            checks++;
            if (i_rdata !== line_of(i_addr)) begin
               errors++; $display("FAIL t6_i_line: addr %h i_rdata=%h", i_addr, i_rdata);
            end
            i_done++;
            if (i_done < 10) i_addr = i_addr + 32'h20;
            else i_read = 1'b0;
         end
         if (d_resp) begin
            checks++;
            if (d_rdata !== line_of(d_addr)) begin
               errors++; $display("FAIL t6_d_line: addr %h d_rdata=%h", d_addr, d_rdata);
            end
            d_done++;
            if (d_done < 10) d_addr = d_addr + 32'h20;
            else d_read = 1'b0;
         end
      end
      bmem_rvalid = 1'b0;
      checks++;
      if (i_done != 10 || d_done != 10 || grants != 20) begin
         errors++; $display("FAIL t6_progress: i_done=%0d d_done=%0d grants=%0d, want 10 10 20", i_done, d_done, grants);
      end
      i_read = 1'b0; d_read = 1'b0;
      tick;
   endtask

   initial begin
      rst_n = 1'b0;
      i_addr = '0; i_read = 1'b0;
      d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
      bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
      tick;
      test_reset;
      test_single_read;
      test_dual_read;
      test_write;
      test_same_line;
      test_reset_mid;
      test_fairness;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
